// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/ack program-memory read with watchdog, opcode/arg split.
// Define PAMPY_FETCH_PREFETCH_EN for the one-entry sequential prefetch buffer.
module instr_fetch_unit #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int TIMEOUT           = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        PC_IN,
  input  logic                         FETCH_REQ,
  output logic                         BUSY,
  output logic                         FETCH_VALID,
  output logic                         FETCH_ERR,
  output logic [DATA_WIDTH-1:0]        INSTR_OUT,
  output logic [DATA_WIDTH-1:0]        ARG_OUT,
  output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
  output logic                         MEM_RD,
  input  logic                         MEM_ACK,
  input  logic [INSTRUCTION_WIDTH-1:0] MEM_DATA
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

`ifdef PAMPY_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {
    IDLE, READ, DONE, PF_READ
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, READ, DONE
  } state_t;
`endif

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    mem_rd_q;
  logic                    valid_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic [DATA_WIDTH-1:0]   arg_q;
  logic [CW-1:0]           wd_cnt;
  logic                    wd_expired;

`ifdef PAMPY_FETCH_PREFETCH_EN
  logic                         buf_valid;
  logic [ADDR_WIDTH-1:0]        buf_addr;
  logic [INSTRUCTION_WIDTH-1:0] buf_data;
  logic                         buf_hit;

  assign buf_hit = buf_valid && (PC_IN == buf_addr);
`endif

  assign wd_expired  = (wd_cnt == WD_LAST);
  assign BUSY        = (state != IDLE);
  assign FETCH_VALID = valid_q;
  assign FETCH_ERR   = err_q;
  assign INSTR_OUT   = instr_q;
  assign ARG_OUT     = arg_q;
  assign MEM_ADDR    = addr_q;
  assign MEM_RD      = mem_rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      mem_rd_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      instr_q   <= '0;
      arg_q     <= '0;
      wd_cnt    <= '0;
`ifdef PAMPY_FETCH_PREFETCH_EN
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (FETCH_REQ) begin
`ifdef PAMPY_FETCH_PREFETCH_EN
            buf_valid <= 1'b0;
            if (buf_hit) begin
              state   <= DONE;
              addr_q  <= PC_IN;
              valid_q <= 1'b1;
              err_q   <= 1'b0;
              instr_q <= buf_data[INSTRUCTION_WIDTH-1 -: DATA_WIDTH];
              arg_q   <= buf_data[DATA_WIDTH-1:0];
            end else begin
              state    <= READ;
              addr_q   <= PC_IN;
              mem_rd_q <= 1'b1;
              wd_cnt   <= '0;
            end
`else
            state    <= READ;
            addr_q   <= PC_IN;
            mem_rd_q <= 1'b1;
            wd_cnt   <= '0;
`endif
          end
        end
        READ: begin
          if (MEM_ACK) begin
            state    <= DONE;
            mem_rd_q <= 1'b0;
            valid_q  <= 1'b1;
            err_q    <= 1'b0;
            instr_q  <= MEM_DATA[INSTRUCTION_WIDTH-1 -: DATA_WIDTH];
            arg_q    <= MEM_DATA[DATA_WIDTH-1:0];
          end else if (wd_expired) begin
            state    <= DONE;
            mem_rd_q <= 1'b0;
            valid_q  <= 1'b1;
            err_q    <= 1'b1;
            instr_q  <= '0;
            arg_q    <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE: begin
`ifdef PAMPY_FETCH_PREFETCH_EN
          // Speculate on the next sequential word unless the fetch failed
          if (!err_q) begin
            state     <= PF_READ;
            addr_q    <= addr_q + 1'b1;
            buf_addr  <= addr_q + 1'b1;
            buf_valid <= 1'b0;
            mem_rd_q  <= 1'b1;
            wd_cnt    <= '0;
          end else begin
            buf_valid <= 1'b0;
            state     <= IDLE;
          end
`else
          if (FETCH_REQ) begin
            state    <= READ;
            addr_q   <= PC_IN;
            mem_rd_q <= 1'b1;
            wd_cnt   <= '0;
          end else begin
            state <= IDLE;
          end
`endif
        end
`ifdef PAMPY_FETCH_PREFETCH_EN
        PF_READ: begin
          if (MEM_ACK) begin
            state     <= IDLE;
            mem_rd_q  <= 1'b0;
            buf_valid <= 1'b1;
            buf_data  <= MEM_DATA;
          end else if (wd_expired) begin
            state     <= IDLE;
            mem_rd_q  <= 1'b0;
            buf_valid <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit, watchdog shortened to 4 cycles.
// Prefetch scenarios run when PAMPY_FETCH_PREFETCH_EN is defined.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [11:0] PC_IN;
  logic        FETCH_REQ;
  logic        BUSY;
  logic        FETCH_VALID;
  logic        FETCH_ERR;
  logic [7:0]  INSTR_OUT;
  logic [7:0]  ARG_OUT;
  logic [11:0] MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_ACK;
  logic [15:0] MEM_DATA;

  int pass_cnt = 0;
  int total    = 0;

  instr_fetch_unit #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(12),
    .INSTRUCTION_WIDTH(16),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PC_IN(PC_IN),
    .FETCH_REQ(FETCH_REQ),
    .BUSY(BUSY),
    .FETCH_VALID(FETCH_VALID),
    .FETCH_ERR(FETCH_ERR),
    .INSTR_OUT(INSTR_OUT),
    .ARG_OUT(ARG_OUT),
    .MEM_ADDR(MEM_ADDR),
    .MEM_RD(MEM_RD),
    .MEM_ACK(MEM_ACK),
    .MEM_DATA(MEM_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset     = 1'b1;
    PC_IN     = '0;
    FETCH_REQ = 1'b0;
    MEM_ACK   = 1'b0;
    MEM_DATA  = '0;
    #12;
    chk("rst_busy", 16'(BUSY), 16'h0);
    chk("rst_valid", 16'(FETCH_VALID), 16'h0);
    chk("rst_rd", 16'(MEM_RD), 16'h0);
    chk("rst_instr", 16'(INSTR_OUT), 16'h0);
    chk("rst_addr", 16'(MEM_ADDR), 16'h0);
    @(posedge clk);
    #1 reset = 1'b0;

`ifndef PAMPY_FETCH_PREFETCH_EN
    // Reset in the middle of a read
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h3AB;
    tick();
    FETCH_REQ = 1'b0;
    chk("a_rd", 16'(MEM_RD), 16'h1);
    chk("a_busy", 16'(BUSY), 16'h1);
    chk("a_addr", 16'(MEM_ADDR), 16'h3AB);
    tick();
    #3 reset = 1'b1;
    #1;
    chk("a_rst_rd", 16'(MEM_RD), 16'h0);
    chk("a_rst_busy", 16'(BUSY), 16'h0);
    chk("a_rst_valid", 16'(FETCH_VALID), 16'h0);
    chk("a_rst_addr", 16'(MEM_ADDR), 16'h0);
    #1 reset = 1'b0;
    tick();
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h010;
    MEM_ACK   = 1'b1;
    MEM_DATA  = 16'h1234;
    tick();
    FETCH_REQ = 1'b0;
    chk("a2_addr", 16'(MEM_ADDR), 16'h010);
    chk("a2_valid0", 16'(FETCH_VALID), 16'h0);
    tick();
    MEM_ACK = 1'b0;
    chk("a2_valid", 16'(FETCH_VALID), 16'h1);
    chk("a2_instr", 16'(INSTR_OUT), 16'h12);
    chk("a2_arg", 16'(ARG_OUT), 16'h34);
    chk("a2_err", 16'(FETCH_ERR), 16'h0);
    chk("a2_rd", 16'(MEM_RD), 16'h0);
    tick();
    chk("a2_valid_end", 16'(FETCH_VALID), 16'h0);
    chk("a2_idle", 16'(BUSY), 16'h0);

    // Three wait cycles before the acknowledge
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h123;
    MEM_DATA  = 16'hA55A;
    tick();
    FETCH_REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b_addr", 16'(MEM_ADDR), 16'h123);
      chk("b_rd", 16'(MEM_RD), 16'h1);
      chk("b_novalid", 16'(FETCH_VALID), 16'h0);
      if (i == 3) MEM_ACK = 1'b1;
      tick();
    end
    MEM_ACK = 1'b0;
    chk("b_valid", 16'(FETCH_VALID), 16'h1);
    chk("b_instr", 16'(INSTR_OUT), 16'hA5);
    chk("b_arg", 16'(ARG_OUT), 16'h5A);
    chk("b_rd_off", 16'(MEM_RD), 16'h0);
    tick();
    chk("b_single", 16'(FETCH_VALID), 16'h0);
    chk("b_hold", 16'(INSTR_OUT), 16'hA5);

    // Watchdog timeout, then a clean fetch
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h200;
    tick();
    FETCH_REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("c_rd", 16'(MEM_RD), 16'h1);
      chk("c_novalid", 16'(FETCH_VALID), 16'h0);
      tick();
    end
    chk("c_valid", 16'(FETCH_VALID), 16'h1);
    chk("c_err", 16'(FETCH_ERR), 16'h1);
    chk("c_instr", 16'(INSTR_OUT), 16'h0);
    chk("c_arg", 16'(ARG_OUT), 16'h0);
    chk("c_rd_off", 16'(MEM_RD), 16'h0);
    tick();
    chk("c_err_hold", 16'(FETCH_ERR), 16'h1);
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h201;
    MEM_ACK   = 1'b1;
    MEM_DATA  = 16'hBEEF;
    tick();
    FETCH_REQ = 1'b0;
    tick();
    MEM_ACK = 1'b0;
    chk("c2_valid", 16'(FETCH_VALID), 16'h1);
    chk("c2_err", 16'(FETCH_ERR), 16'h0);
    chk("c2_instr", 16'(INSTR_OUT), 16'hBE);
    chk("c2_arg", 16'(ARG_OUT), 16'hEF);
    tick();

    // Request held while busy with PC_IN changing
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h001;
    tick();
    PC_IN = 12'h002;
    chk("d_addr1", 16'(MEM_ADDR), 16'h001);
    tick();
    chk("d_addr1b", 16'(MEM_ADDR), 16'h001);
    chk("d_busy", 16'(BUSY), 16'h1);
    MEM_ACK  = 1'b1;
    MEM_DATA = 16'h0101;
    tick();
    MEM_ACK = 1'b0;
    chk("d_valid1", 16'(FETCH_VALID), 16'h1);
    chk("d_instr1", 16'(INSTR_OUT), 16'h01);
    chk("d_addr_done", 16'(MEM_ADDR), 16'h001);
    tick();
    chk("d_addr2", 16'(MEM_ADDR), 16'h002);
    chk("d_rd2", 16'(MEM_RD), 16'h1);
    chk("d_novalid", 16'(FETCH_VALID), 16'h0);
    FETCH_REQ = 1'b0;
    MEM_ACK   = 1'b1;
    MEM_DATA  = 16'h0202;
    tick();
    MEM_ACK = 1'b0;
    chk("d_valid2", 16'(FETCH_VALID), 16'h1);
    chk("d_arg2", 16'(ARG_OUT), 16'h02);
    tick();
    chk("d_idle", 16'(BUSY), 16'h0);
    chk("d_rd_idle", 16'(MEM_RD), 16'h0);
`else
    // Straight-line hit at 0x100 after fetching 0x0FF
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h0FF;
    MEM_ACK   = 1'b1;
    MEM_DATA  = 16'h1111;
    tick();
    FETCH_REQ = 1'b0;
    tick();
    MEM_ACK = 1'b0;
    chk("e_valid", 16'(FETCH_VALID), 16'h1);
    chk("e_instr", 16'(INSTR_OUT), 16'h11);
    tick();
    chk("e_pf_addr", 16'(MEM_ADDR), 16'h100);
    chk("e_pf_rd", 16'(MEM_RD), 16'h1);
    chk("e_pf_busy", 16'(BUSY), 16'h1);
    chk("e_pf_novalid", 16'(FETCH_VALID), 16'h0);
    MEM_ACK  = 1'b1;
    MEM_DATA = 16'h2222;
    tick();
    MEM_ACK = 1'b0;
    chk("e_buf_rd", 16'(MEM_RD), 16'h0);
    chk("e_buf_busy", 16'(BUSY), 16'h0);
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h100;
    tick();
    FETCH_REQ = 1'b0;
    chk("e_hit_valid", 16'(FETCH_VALID), 16'h1);
    chk("e_hit_instr", 16'(INSTR_OUT), 16'h22);
    chk("e_hit_rd", 16'(MEM_RD), 16'h0);
    tick();
    chk("e_pf2_addr", 16'(MEM_ADDR), 16'h101);
    chk("e_pf2_rd", 16'(MEM_RD), 16'h1);
    MEM_ACK  = 1'b1;
    MEM_DATA = 16'h3333;
    tick();
    MEM_ACK   = 1'b0;
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h050;
    tick();
    FETCH_REQ = 1'b0;
    chk("e_miss_addr", 16'(MEM_ADDR), 16'h050);
    chk("e_miss_rd", 16'(MEM_RD), 16'h1);
    chk("e_miss_novalid", 16'(FETCH_VALID), 16'h0);
    MEM_ACK  = 1'b1;
    MEM_DATA = 16'h5050;
    tick();
    MEM_ACK = 1'b0;
    chk("e_miss_valid", 16'(FETCH_VALID), 16'h1);
    chk("e_miss_instr", 16'(INSTR_OUT), 16'h50);
    tick();
    chk("e_pf3_addr", 16'(MEM_ADDR), 16'h051);
    for (int i = 0; i < 4; i++) tick();
    chk("e_to_valid", 16'(FETCH_VALID), 16'h0);
    chk("e_to_err", 16'(FETCH_ERR), 16'h0);
    chk("e_to_idle", 16'(BUSY), 16'h0);

    // Prefetch address wraps from 0xFFF to 0x000
    FETCH_REQ = 1'b1;
    PC_IN     = 12'hFFF;
    MEM_ACK   = 1'b1;
    MEM_DATA  = 16'hF0F0;
    tick();
    FETCH_REQ = 1'b0;
    tick();
    MEM_ACK = 1'b0;
    chk("f_valid", 16'(FETCH_VALID), 16'h1);
    tick();
    chk("f_wrap_addr", 16'(MEM_ADDR), 16'h000);
    MEM_ACK  = 1'b1;
    MEM_DATA = 16'h0A0B;
    tick();
    MEM_ACK   = 1'b0;
    FETCH_REQ = 1'b1;
    PC_IN     = 12'h000;
    tick();
    FETCH_REQ = 1'b0;
    chk("f_hit_valid", 16'(FETCH_VALID), 16'h1);
    chk("f_hit_instr", 16'(INSTR_OUT), 16'h0A);
    chk("f_hit_arg", 16'(ARG_OUT), 16'h0B);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
